pipe_if_fetch: RTL and testbench
================================

// Module: pipe_if_fetch
// PURPOSE
//  Instruction-fetch stage directly upstream of the decode stage. Owns the PC and the IF/ID
//  pipeline register, drives the instruction-memory address, and delivers instr/pc/pc+4/valid
//  to decode. Honours load-use stall from the hazard unit and redirect (taken branch/jump) from EX.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0013  bubble instruction (addi x0,x0,0) placed in IF/ID on flush/wait
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  imem_addr      out  32  fetch address (= current PC, bits[1:0] always 0)
//  imem_rdata     in   32  instruction word for imem_addr, combinational same-cycle
//  imem_ready     in   1   1 = imem_rdata valid this cycle; 0 = wait state
//  stall          in   1   hold PC and IF/ID (load-use hazard, decode busy)
//  redirect       in   1   taken branch/jump resolved in EX; flush and refetch
//  redirect_pc    in   32  target address when redirect=1
//  instr2id       out  32  IF/ID instruction to decode
//  pc2id          out  32  IF/ID PC of instr2id
//  pc4_2id        out  32  IF/ID pc2id+4 (JAL/JALR link value)
//  valid2id       out  1   1 = instr2id is a real fetched instruction
//  misalign_err   out  1   sticky: a redirect target had bits[1:0]!=0
// BEHAVIOUR
//  Reset (rst=1 at edge): PC<=RESET_PC; instr2id<=NOP_INSTR; pc2id<=0; pc4_2id<=0;
//   valid2id<=0; misalign_err<=0. rst overrides every other input that cycle.
//  Priority per edge: rst > redirect > stall > imem wait > normal advance.
//  Normal (imem_ready=1, stall=0, redirect=0): IF/ID<={imem_rdata,PC,PC+4,1}; PC<=PC+4.
//   Latency: PC presented in cycle N appears on instr2id/pc2id in cycle N+1.
//  Wait (imem_ready=0, stall=0, redirect=0): PC holds; IF/ID<={NOP_INSTR,PC,PC+4,0} (bubble).
//  Stall (stall=1, redirect=0): PC and all IF/ID outputs hold, regardless of imem_ready.
//  Redirect (redirect=1): PC<={redirect_pc[31:2],2'b00}; IF/ID<=bubble (valid2id=0,
//   instr2id=NOP_INSTR); wins over simultaneous stall. If redirect_pc[1:0]!=0, set
//   misalign_err (cleared only by rst).
//  Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC advances to 32'h0000_0000, no flag.
//  imem_addr = PC combinationally; never depends on stall/redirect of the current cycle.
//  Reset mid-wait or mid-stall: state discarded; first fetch after rst deasserts is RESET_PC.
//  Two-state view: RUN (advancing) / HOLD (stall or wait); not a separate register,
//   derived from inputs each cycle; no multi-cycle request tracking.
// STRUCTURE
//  Shared package pipe_pkg: NOP_INSTR constant, RESET_PC default, IF/ID bundle field
//   widths (XLEN=32) reused by decode and later pipeline registers.
//  One natural sub-module: if_id_reg (IF/ID register with hold/flush controls); PC
//   register and next-PC mux stay in this module.
// TESTING
//  1 Reset: rst=1 two cycles, release -> imem_addr=0x0, valid2id=0, instr2id=0x00000013;
//    next cycle with imem_rdata=0x00500093 -> instr2id=0x00500093, pc2id=0x0, pc4_2id=0x4.
//  2 Stall: streaming from 0x10, stall=1 for 3 cycles -> imem_addr stays 0x14,
//    instr2id/pc2id=0x10 frozen; stall drop -> pc2id=0x14 next cycle, no skipped/duplicated PC.
//  3 Redirect vs stall: stall=1 and redirect=1 redirect_pc=0x80 same edge -> imem_addr=0x80,
//    valid2id=0, instr2id=NOP; next edge pc2id=0x80, valid2id=1.
//  4 Wait states: imem_ready=0 two cycles at PC=0x20 -> two bubbles (valid2id=0),
//    imem_addr=0x20 held; ready=1 -> pc2id=0x20, valid2id=1.
//  5 Misaligned/wrap: redirect_pc=0x102 -> imem_addr=0x100, misalign_err=1 sticky;
//    redirect to 0xFFFFFFFC then advance -> imem_addr=0x0.
//  6 Reset mid-stall: stall=1 at PC=0x40, pulse rst -> PC=RESET_PC, valid2id=0, err cleared.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline definitions. It holds the datapath width, the bubble
// instruction and the reset PC. It also defines the IF/ID bundle layout,
// which decode and later pipeline registers reuse, the per-edge IF/ID
// register control, and the address helper functions.
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int          XLEN        = 32;
  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;

  // IF/ID bundle carried from fetch to decode
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

  // Per-edge action on the IF/ID register
  typedef enum logic [1:0] {
    IFID_ADVANCE = 2'd0,  // capture a fetched instruction
    IFID_BUBBLE  = 2'd1,  // capture a NOP with valid cleared
    IFID_HOLD    = 2'd2   // keep current contents
  } if_id_ctl_e;

  // Sequential PC increment; wraps modulo 2^32 without a flag
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  // A fetch target must be word aligned
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pipe_if_fetch_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with advance, bubble and hold controls.
// A bubble keeps the PC fields of the incoming bundle. It forces the
// instruction to NOP and clears valid.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   ctl        per-edge action (advance / bubble / hold)
//   d          incoming bundle from the fetch stage
//   instr_q    registered instruction
//   pc_q       registered PC
//   pc4_q      registered PC+4
//   valid_q    registered valid flag
// ---------------------------------------------------------------------------
module if_id_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        rst,
  input  if_id_ctl_e  ctl,
  input  if_id_t      d,
  output logic [31:0] instr_q,
  output logic [31:0] pc_q,
  output logic [31:0] pc4_q,
  output logic        valid_q
);

  if_id_t ifid_r;

  // IF/ID state update: reset, capture, bubble or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_r.instr <= NOP_INSTR;
      ifid_r.pc    <= 32'h0000_0000;
      ifid_r.pc4   <= 32'h0000_0000;
      ifid_r.valid <= 1'b0;
    end else begin
      case (ctl)
        IFID_ADVANCE: ifid_r <= d;
        IFID_BUBBLE: begin
          ifid_r.instr <= NOP_INSTR;
          ifid_r.pc    <= d.pc;
          ifid_r.pc4   <= d.pc4;
          ifid_r.valid <= 1'b0;
        end
        IFID_HOLD:    ifid_r <= ifid_r;
        default:      ifid_r <= ifid_r;
      endcase
    end
  end

  assign instr_q = ifid_r.instr;
  assign pc_q    = ifid_r.pc;
  assign pc4_q   = ifid_r.pc4;
  assign valid_q = ifid_r.valid;

endmodule

// File: rtl/pipe_if_fetch.sv
// ---------------------------------------------------------------------------
// pipe_if_fetch
// Instruction-fetch stage. It owns the PC and the next-PC mux, and it feeds
// the IF/ID register into decode.
// Priority on each edge: rst > redirect > stall > imem wait > advance.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   imem_addr             fetch address (the current PC, always word aligned)
//   imem_rdata            same-cycle instruction word for imem_addr
//   imem_ready            1 = imem_rdata valid, 0 = wait state
//   stall                 hold the PC and IF/ID
//   redirect              taken branch/jump from EX
//   redirect_pc           redirect target
//   instr2id              IF/ID instruction to decode
//   pc2id                 IF/ID PC
//   pc4_2id               IF/ID PC+4
//   valid2id              IF/ID valid flag
//   misalign_err          sticky flag, set by an unaligned redirect target
// ---------------------------------------------------------------------------
module pipe_if_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_C,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr2id,
  output logic [31:0] pc2id,
  output logic [31:0] pc4_2id,
  output logic        valid2id,
  output logic        misalign_err
);

  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [31:0] pc4_s;
  logic        misalign_r;
  if_id_ctl_e  ifid_ctl_s;
  if_id_t      ifid_d_s;

  assign pc4_s = pc_plus4(pc_r);

  // Next-PC selection and IF/ID action; RUN vs HOLD is decided from this cycle's inputs only
  always_comb begin
    pc_next_s  = pc_r;
    ifid_ctl_s = IFID_HOLD;
    if (redirect) begin
      pc_next_s  = {redirect_pc[31:2], 2'b00};
      ifid_ctl_s = IFID_BUBBLE;
    end else if (stall) begin
      pc_next_s  = pc_r;
      ifid_ctl_s = IFID_HOLD;
    end else if (!imem_ready) begin
      pc_next_s  = pc_r;
      ifid_ctl_s = IFID_BUBBLE;
    end else begin
      pc_next_s  = pc4_s;
      ifid_ctl_s = IFID_ADVANCE;
    end
  end

  // Bundle presented to IF/ID; used as-is on advance, PC fields only on bubble
  always_comb begin
    ifid_d_s.instr = imem_rdata;
    ifid_d_s.pc    = pc_r;
    ifid_d_s.pc4   = pc4_s;
    ifid_d_s.valid = 1'b1;
  end

  // PC register; the reset value is forced to word alignment
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= {RESET_PC[31:2], 2'b00};
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // Sticky misalignment flag; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else if (redirect && is_misaligned(redirect_pc)) begin
      misalign_r <= 1'b1;
    end else begin
      misalign_r <= misalign_r;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .ctl     (ifid_ctl_s),
    .d       (ifid_d_s),
    .instr_q (instr2id),
    .pc_q    (pc2id),
    .pc4_q   (pc4_2id),
    .valid_q (valid2id)
  );

  assign imem_addr    = pc_r;
  assign misalign_err = misalign_r;

endmodule

// File: tb/tb_pipe_if_fetch.sv
// Directed bench for pipe_if_fetch. The instruction memory model returns
// {addr[15:0], 16'h0A03} unless a fixed word is forced. Inputs change 1 ns
// after the rising edge, and outputs are sampled at the same point.
module tb_pipe_if_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr2id;
  logic [31:0] pc2id;
  logic [31:0] pc4_2id;
  logic        valid2id;
  logic        misalign_err;

  logic        use_fixed;
  logic [31:0] fixed_rdata;
  int          vectors;
  int          miscompares;

  assign imem_rdata = use_fixed ? fixed_rdata : {imem_addr[15:0], 16'h0A03};

  pipe_if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr2id     (instr2id),
    .pc2id        (pc2id),
    .pc4_2id      (pc4_2id),
    .valid2id     (valid2id),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    step();
    redirect    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; use_fixed = 1'b1; fixed_rdata = 32'h0050_0093;
    step();
    step();
    vectors++;
    if (imem_addr !== 32'h0 || valid2id !== 1'b0 || instr2id !== 32'h0000_0013 ||
        pc2id !== 32'h0 || pc4_2id !== 32'h0 || misalign_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: addr=%h valid=%b instr=%h pc=%h pc4=%h err=%b, need 0/0/00000013/0/0/0",
               imem_addr, valid2id, instr2id, pc2id, pc4_2id, misalign_err);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (instr2id !== 32'h0050_0093 || pc2id !== 32'h0 || pc4_2id !== 32'h4 ||
        valid2id !== 1'b1 || imem_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL first_fetch: instr=%h pc=%h pc4=%h valid=%b addr=%h, need 00500093/0/4/1/4",
               instr2id, pc2id, pc4_2id, valid2id, imem_addr);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_stall();
    do_redirect(32'h10);
    step();
    vectors++;
    if (pc2id !== 32'h10 || instr2id !== 32'h0010_0A03 || imem_addr !== 32'h14) begin
      miscompares++;
      $display("FAIL stall_prefill: pc=%h instr=%h addr=%h, need 10/00100a03/14", pc2id, instr2id, imem_addr);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (imem_addr !== 32'h14 || pc2id !== 32'h10 || instr2id !== 32'h0010_0A03 || valid2id !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold%0d: addr=%h pc=%h instr=%h valid=%b, need 14/10/00100a03/1",
                 i, imem_addr, pc2id, instr2id, valid2id);
      end
    end
    stall = 1'b0;
    step();
    vectors++;
    if (pc2id !== 32'h14 || instr2id !== 32'h0014_0A03 || pc4_2id !== 32'h18 ||
        valid2id !== 1'b1 || imem_addr !== 32'h18) begin
      miscompares++;
      $display("FAIL stall_release: pc=%h instr=%h pc4=%h valid=%b addr=%h, need 14/00140a03/18/1/18",
               pc2id, instr2id, pc4_2id, valid2id, imem_addr);
    end
  endtask

  task automatic test_redirect_vs_stall();
    stall = 1'b1;
    do_redirect(32'h80);
    stall = 1'b0;
    vectors++;
    if (imem_addr !== 32'h80 || valid2id !== 1'b0 || instr2id !== 32'h0000_0013) begin
      miscompares++;
      $display("FAIL redir_stall: addr=%h valid=%b instr=%h, need 80/0/00000013", imem_addr, valid2id, instr2id);
    end
    step();
    vectors++;
    if (pc2id !== 32'h80 || valid2id !== 1'b1 || instr2id !== 32'h0080_0A03 || imem_addr !== 32'h84) begin
      miscompares++;
      $display("FAIL redir_refetch: pc=%h valid=%b instr=%h addr=%h, need 80/1/00800a03/84",
               pc2id, valid2id, instr2id, imem_addr);
    end
  endtask

  task automatic test_wait_states();
    do_redirect(32'h20);
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (valid2id !== 1'b0 || imem_addr !== 32'h20 || instr2id !== 32'h0000_0013) begin
        miscompares++;
        $display("FAIL wait_bubble%0d: valid=%b addr=%h instr=%h, need 0/20/00000013",
                 i, valid2id, imem_addr, instr2id);
      end
    end
    imem_ready = 1'b1;
    step();
    vectors++;
    if (pc2id !== 32'h20 || valid2id !== 1'b1 || instr2id !== 32'h0020_0A03 || imem_addr !== 32'h24) begin
      miscompares++;
      $display("FAIL wait_release: pc=%h valid=%b instr=%h addr=%h, need 20/1/00200a03/24",
               pc2id, valid2id, instr2id, imem_addr);
    end
  endtask

  task automatic test_misalign_wrap();
    vectors++;
    if (misalign_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear_before: err=%b, need 0", misalign_err);
    end
    do_redirect(32'h102);
    vectors++;
    if (imem_addr !== 32'h100 || misalign_err !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_set: addr=%h err=%b, need 100/1", imem_addr, misalign_err);
    end
    step();
    vectors++;
    if (misalign_err !== 1'b1 || pc2id !== 32'h100 || valid2id !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_sticky: err=%b pc=%h valid=%b, need 1/100/1", misalign_err, pc2id, valid2id);
    end
    do_redirect(32'hFFFF_FFFC);
    step();
    vectors++;
    if (imem_addr !== 32'h0 || pc2id !== 32'hFFFF_FFFC || pc4_2id !== 32'h0 ||
        instr2id !== 32'hFFFC_0A03 || misalign_err !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap: addr=%h pc=%h pc4=%h instr=%h err=%b, need 0/fffffffc/0/fffc0a03/1",
               imem_addr, pc2id, pc4_2id, instr2id, misalign_err);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_redirect(32'h40);
    stall = 1'b1;
    step();
    vectors++;
    if (imem_addr !== 32'h40 || valid2id !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset_stall: addr=%h valid=%b, need 40/0", imem_addr, valid2id);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (imem_addr !== 32'h0 || valid2id !== 1'b0 || misalign_err !== 1'b0 || instr2id !== 32'h0000_0013) begin
      miscompares++;
      $display("FAIL reset_mid_stall: addr=%h valid=%b err=%b instr=%h, need 0/0/0/00000013",
               imem_addr, valid2id, misalign_err, instr2id);
    end
    stall = 1'b0;
    step();
    vectors++;
    if (pc2id !== 32'h0 || valid2id !== 1'b1 || instr2id !== 32'h0000_0A03 || imem_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL post_reset_fetch: pc=%h valid=%b instr=%h addr=%h, need 0/1/00000a03/4",
               pc2id, valid2id, instr2id, imem_addr);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_stall();
    test_redirect_vs_stall();
    test_wait_states();
    test_misalign_wrap();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
